// File: rtl/video_write_port.sv
// CPU write-bus responder: buffers playfield RAM writes in a FIFO drained on
// video grant cycles, and double-buffers sprite/background registers per frame.
module video_write_port #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] REG_BASE   = 16'hF000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Cpu_Write,
  input  logic [15:0] i_Cpu_Addr,
  input  logic [15:0] i_Cpu_Data,
  output logic        o_Cpu_Stall,
  input  logic        i_Frame_Start,
  input  logic        i_Pf_Grant,
  output logic        o_Pf_Write,
  output logic [9:0]  o_Pf_Addr,
  output logic [7:0]  o_Pf_Data,
  output logic [5:0]  o_Sprite_Num,
  output logic [9:0]  o_Sprite_X,
  output logic [9:0]  o_Sprite_Y,
  output logic        o_Sprite_En,
  output logic [8:0]  o_Bg_Color,
  output logic [7:0]  o_Drop_Count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [15:0] ADDR_NUM = REG_BASE + 16'd0;
  localparam logic [15:0] ADDR_X   = REG_BASE + 16'd1;
  localparam logic [15:0] ADDR_Y   = REG_BASE + 16'd2;
  localparam logic [15:0] ADDR_EN  = REG_BASE + 16'd3;
  localparam logic [15:0] ADDR_BG  = REG_BASE + 16'd4;

  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;

  logic [5:0] sh_num_q, sh_num_d;
  logic [9:0] sh_x_q, sh_x_d;
  logic [9:0] sh_y_q, sh_y_d;
  logic       sh_en_q, sh_en_d;
  logic [8:0] sh_bg_q, sh_bg_d;

  logic [5:0] act_num_q;
  logic [9:0] act_x_q;
  logic [9:0] act_y_q;
  logic       act_en_q;
  logic [8:0] act_bg_q;

  logic full, empty, pf_hit, push, pop, drop;
  logic unused_data_bits;

  assign unused_data_bits = ^i_Cpu_Data[15:10];

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign pf_hit = i_Cpu_Write && (i_Cpu_Addr[15:10] == 6'd0);
  // A full FIFO drops the write even when a pop frees a slot this same cycle.
  assign push   = pf_hit && !full;
  assign drop   = pf_hit && full;
  assign pop    = i_Pf_Grant && !empty;

  assign o_Cpu_Stall = full;
  assign o_Pf_Write  = pop;
  assign o_Pf_Addr   = empty ? 10'd0 : mem_q[rd_ptr_q][17:8];
  assign o_Pf_Data   = empty ? 8'd0  : mem_q[rd_ptr_q][7:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    sh_num_d = sh_num_q;
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    sh_en_d  = sh_en_q;
    sh_bg_d  = sh_bg_q;
    if (i_Cpu_Write) begin
      if (i_Cpu_Addr == ADDR_NUM) sh_num_d = i_Cpu_Data[5:0];
      if (i_Cpu_Addr == ADDR_X)   sh_x_d   = i_Cpu_Data[9:0];
      if (i_Cpu_Addr == ADDR_Y)   sh_y_d   = i_Cpu_Data[9:0];
      if (i_Cpu_Addr == ADDR_EN)  sh_en_d  = i_Cpu_Data[0];
      if (i_Cpu_Addr == ADDR_BG)  sh_bg_d  = i_Cpu_Data[8:0];
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge i_Clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_Cpu_Addr[9:0], i_Cpu_Data[7:0]};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Committing the next-state shadow gives write-through on a frame-start write.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sh_num_q  <= '0;
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_en_q   <= 1'b0;
      sh_bg_q   <= '0;
      act_num_q <= '0;
      act_x_q   <= '0;
      act_y_q   <= '0;
      act_en_q  <= 1'b0;
      act_bg_q  <= '0;
    end else begin
      sh_num_q <= sh_num_d;
      sh_x_q   <= sh_x_d;
      sh_y_q   <= sh_y_d;
      sh_en_q  <= sh_en_d;
      sh_bg_q  <= sh_bg_d;
      if (i_Frame_Start) begin
        act_num_q <= sh_num_d;
        act_x_q   <= sh_x_d;
        act_y_q   <= sh_y_d;
        act_en_q  <= sh_en_d;
        act_bg_q  <= sh_bg_d;
      end
    end
  end

  assign o_Sprite_Num = act_num_q;
  assign o_Sprite_X   = act_x_q;
  assign o_Sprite_Y   = act_y_q;
  assign o_Sprite_En  = act_en_q;
  assign o_Bg_Color   = act_bg_q;
  assign o_Drop_Count = drop_q;

endmodule
